// File: rtl/uk101_ps2_rx_pkg.sv
// UK101 PS/2 keyboard receiver: shared constants
// and FSM state encoding.
package uk101_ps2_rx_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
  localparam int         PS2_FRAME_BITS   = 11;

  // start + parity + stop surround the data bits
  localparam int PS2_DATA_BITS = PS2_FRAME_BITS - 3;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  function automatic logic ps2_odd_ok(
    input logic [7:0] b,
    input logic       p
  );
    return ^{b, p};
  endfunction

endpackage

// File: rtl/uk101_ps2_filter.sv
// Two-flop synchroniser with an optional
// level filter for the raw PS/2 lines.
module uk101_ps2_filter #(
  parameter int FILTER_LEN = 8,
  parameter bit FILTER_EN  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], d_i};
  end

  generate
    if (FILTER_EN) begin : g_filt
      localparam int CW =
        (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

      logic          level_q, level_d;
      logic [CW-1:0] cnt_q, cnt_d;

      // count consecutive samples that disagree
      // with the accepted level
      always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
          if (cnt_q == CW'(FILTER_LEN - 1))
            level_d = sync_q[1];
          else
            cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          level_q <= 1'b1;
          cnt_q   <= '0;
        end else begin
          level_q <= level_d;
          cnt_q   <= cnt_d;
        end
      end

      assign q_o = level_q;
    end else begin : g_raw
      assign q_o = sync_q[1];
    end
  endgenerate

endmodule

// File: rtl/uk101_ps2_rx.sv
// UK101 PS/2 receiver: frames keyboard bytes and
// folds E0/F0 prefixes into extended/released.
module uk101_ps2_rx
  import uk101_ps2_rx_pkg::*;
#(
  parameter int clk_mhz    = 25,
  parameter int timeout_us = 200,
  parameter int filter_len = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       released,
  output logic       valid,
  output logic       error
);

  localparam int TMO_CYC = clk_mhz * timeout_us;
  localparam int TW      = $clog2(TMO_CYC + 1);

  logic clk_f;
  logic data_s;
  logic fclk_prev_q;
  logic fall;

  ps2_state_e state_q, state_d;

  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          pend_ext_q, pend_ext_d;
  logic          pend_brk_q, pend_brk_d;
  logic [7:0]    code_q, code_d;
  logic          ext_q, ext_d;
  logic          rel_q, rel_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;

  uk101_ps2_filter #(
    .FILTER_LEN (filter_len),
    .FILTER_EN  (1'b1)
  ) u_clk_filt (
    .clk   (clk),
    .reset (reset),
    .d_i   (ps2clk),
    .q_o   (clk_f)
  );

  uk101_ps2_filter #(
    .FILTER_LEN (filter_len),
    .FILTER_EN  (1'b0)
  ) u_dat_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (ps2data),
    .q_o   (data_s)
  );

  assign fall = fclk_prev_q & ~clk_f;

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    pend_ext_d = pend_ext_q;
    pend_brk_d = pend_brk_q;
    code_d     = code_q;
    ext_d      = ext_q;
    rel_d      = rel_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;

    if (fall)
      tmo_d = '0;
    else if (tmo_q == TW'(TMO_CYC))
      tmo_d = tmo_q;
    else
      tmo_d = tmo_q + 1'b1;

    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end
        end
        DATA: begin
          shift_d  = {data_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'(PS2_DATA_BITS - 1))
            state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (ps2_odd_ok(shift_q, par_q) && data_s) begin
            if (shift_q == PS2_PREFIX_EXT) begin
              pend_ext_d = 1'b1;
            end else if (shift_q == PS2_PREFIX_BREAK) begin
              pend_brk_d = 1'b1;
            end else begin
              code_d     = shift_q;
              ext_d      = pend_ext_q;
              rel_d      = pend_brk_q;
              valid_d    = 1'b1;
              pend_ext_d = 1'b0;
              pend_brk_d = 1'b0;
            end
          end else begin
            error_d    = 1'b1;
            pend_ext_d = 1'b0;
            pend_brk_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE &&
                 tmo_q == TW'(TMO_CYC)) begin
      // keyboard stalled mid-frame: drop it
      state_d    = IDLE;
      error_d    = 1'b1;
      pend_ext_d = 1'b0;
      pend_brk_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fclk_prev_q <= 1'b1;
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      pend_ext_q  <= 1'b0;
      pend_brk_q  <= 1'b0;
      code_q      <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      fclk_prev_q <= clk_f;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      pend_ext_q  <= pend_ext_d;
      pend_brk_q  <= pend_brk_d;
      code_q      <= code_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
    end
  end

  assign scancode = code_q;
  assign extended = ext_q;
  assign released = rel_q;
  assign valid    = valid_q;
  assign error    = error_q;

endmodule

// File: tb/tb_uk101_ps2_rx.sv
// Directed plus randomized frames against a
// byte-level model of prefix handling.
`timescale 1ns/1ps
module tb_uk101_ps2_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2clk;
  logic       ps2data;
  logic [7:0] scancode;
  logic       extended;
  logic       released;
  logic       valid;
  logic       error;

  always #20 clk = ~clk;

  uk101_ps2_rx dut (
    .clk      (clk),
    .reset    (reset),
    .ps2clk   (ps2clk),
    .ps2data  (ps2data),
    .scancode (scancode),
    .extended (extended),
    .released (released),
    .valid    (valid),
    .error    (error)
  );

  int tests  = 0;
  int failed = 0;

  int         vcnt = 0, ecnt = 0;
  int         both_cnt = 0, long_cnt = 0;
  logic [7:0] cap_code = '0;
  logic       cap_ext = 0, cap_rel = 0;
  logic       prev_valid = 0, prev_error = 0;

  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      cap_code = scancode;
      cap_ext  = extended;
      cap_rel  = released;
    end
    if (error) ecnt++;
    if (valid && error) both_cnt++;
    if ((valid && prev_valid) || (error && prev_error))
      long_cnt++;
    prev_valid = valid;
    prev_error = error;
  end

  int         exp_v = 0, exp_e = 0;
  logic       m_ext = 0, m_brk = 0;
  logic [7:0] m_code = '0;
  logic       m_cext = 0, m_crel = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_frame(input logic [7:0] b,
                             input bit good);
    if (!good) begin
      exp_e++;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      exp_v++;
      m_code = b;
      m_cext = m_ext;
      m_crel = m_brk;
      m_ext  = 0;
      m_brk  = 0;
    end
  endtask

  task automatic send(input logic [7:0] b,
                      input bit flip,
                      input int nedges,
                      input int half);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nedges; i++) begin
      ps2data = f[i];
      repeat (half) @(negedge clk);
      ps2clk = 1'b0;
      repeat (half) @(negedge clk);
      ps2clk = 1'b1;
    end
    ps2data = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".vcnt"}, vcnt, exp_v);
    chk({tag, ".ecnt"}, ecnt, exp_e);
    chk({tag, ".code"}, cap_code, m_code);
    chk({tag, ".ext"}, cap_ext, m_cext);
    chk({tag, ".rel"}, cap_rel, m_crel);
  endtask

  task automatic frame(input string tag,
                       input logic [7:0] b,
                       input bit flip,
                       input int half);
    send(b, flip, 11, half);
    model_frame(b, !flip);
    repeat (5) @(negedge clk);
    check_all(tag);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, ".scancode"}, scancode, 8'h00);
    chk({tag, ".extended"}, extended, 1'b0);
    chk({tag, ".released"}, released, 1'b0);
    chk({tag, ".valid"}, valid, 1'b0);
    chk({tag, ".error"}, error, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    bit         fl;

    reset   = 1'b1;
    ps2clk  = 1'b1;
    ps2data = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero_outs("reset");
    reset = 1'b0;
    repeat (20) @(negedge clk);

    frame("slow_1c", 8'h1C, 0, 1000);

    frame("brk_f0", 8'hF0, 0, 40);
    frame("brk_1c", 8'h1C, 0, 40);
    frame("ext_e0", 8'hE0, 0, 40);
    frame("ext_f0", 8'hF0, 0, 40);
    frame("ext_75", 8'h75, 0, 40);

    frame("par_1c", 8'h1C, 1, 40);
    frame("par_32", 8'h32, 0, 40);

    frame("tmo_e0", 8'hE0, 0, 40);
    send(8'h5A, 0, 6, 40);
    repeat (4910) @(negedge clk);
    chk("tmo_early", ecnt, exp_e);
    repeat (150) @(negedge clk);
    model_frame(8'h00, 0);
    chk("tmo_err", ecnt, exp_e);
    frame("tmo_1c", 8'h1C, 0, 40);

    ps2data = 1'b0;
    ps2clk  = 1'b0;
    repeat (3) @(negedge clk);
    ps2clk  = 1'b1;
    ps2data = 1'b1;
    repeat (50) @(negedge clk);
    chk("glitch_v", vcnt, exp_v);
    chk("glitch_e", ecnt, exp_e);
    frame("glitch_1c", 8'h1C, 0, 40);

    frame("rst_e0", 8'hE0, 0, 40);
    send(8'h33, 0, 4, 40);
    reset = 1'b1;
    #1;
    chk_zero_outs("rst_mid");
    m_ext = 0;
    m_brk = 0;
    ps2clk  = 1'b1;
    ps2data = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    frame("rst_1c", 8'h1C, 0, 40);

    for (int k = 0; k < 16; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else             b = 8'($urandom);
      fl = ($urandom_range(0, 7) == 0);
      frame($sformatf("rnd%0d", k), b, fl,
            $urandom_range(20, 60));
    end

    chk("valid_and_error", both_cnt, 0);
    chk("pulse_width", long_cnt, 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, failed);
    $finish;
  end

endmodule

// File: doc/uk101_ps2_rx.md
UK101_PS2_RX -- requirements
Module: uk101_ps2_rx

Interface
REQ-001 SHALL have parameter clk_mhz, default 25, system clock frequency in MHz.
REQ-002 SHALL have parameter timeout_us, default 200, maximum allowed gap between PS/2 clock falling edges inside a frame.
REQ-003 SHALL have parameter filter_len, default 8, number of consecutive equal samples needed to accept a new ps2clk level.
REQ-004 SHALL have port clk, input, 1, system clock; all logic in this single clock domain.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port ps2clk, input, 1, raw PS/2 clock from the keyboard pin, asynchronous.
REQ-007 SHALL have port ps2data, input, 1, raw PS/2 data from the keyboard pin, asynchronous.
REQ-008 SHALL have port scancode, output, 8, last accepted make/break code byte, excluding prefixes.
REQ-009 SHALL have port extended, output, 1, high when an E0 prefix preceded scancode.
REQ-010 SHALL have port released, output, 1, high when an F0 prefix preceded scancode.
REQ-011 SHALL have port valid, output, 1, one-cycle strobe qualifying scancode, extended and released.
REQ-012 SHALL have port error, output, 1, one-cycle strobe on a parity, start, stop or timeout failure.

Function
REQ-013 SHALL synchronise ps2clk and ps2data through two flip-flops each before any use.
REQ-014 SHALL change the filtered clock level only after filter_len consecutive synchronised samples at the new level; shorter pulses are ignored.
REQ-015 SHALL act only on filtered-clock falling edges, sampling the synchronised ps2data in the same cycle the edge is detected.
REQ-016 SHALL use the states IDLE, DATA, PARITY and STOP.
REQ-017 In IDLE, a falling edge with data 0 (start bit) SHALL go to DATA with the bit count at 0; a falling edge with data 1 SHALL be ignored and the FSM stays in IDLE.
REQ-018 In DATA, each edge SHALL shift data in LSB first; after the 8th bit the FSM SHALL go to PARITY.
REQ-019 In PARITY, the edge SHALL record the bit and the FSM SHALL go to STOP; parity is odd over the 8 data bits plus the parity bit.
REQ-020 In STOP, the edge SHALL return the FSM to IDLE; a frame is good only if parity is correct and the stop bit is 1.
REQ-021 A good frame with byte E0 SHALL set the pending-extended flag and SHALL NOT pulse valid.
REQ-022 A good frame with byte F0 SHALL set the pending-released flag and SHALL NOT pulse valid.
REQ-023 A good frame with any other byte SHALL, one cycle after the stop edge:
- load scancode with the byte;
- load extended and released from the pending flags;
- pulse valid for one cycle;
- clear both pending flags.
REQ-024 A bad frame SHALL pulse error for one cycle, clear both pending flags and leave scancode, extended and released unchanged.
REQ-025 In any state other than IDLE, if clk_mhz*timeout_us cycles pass with no falling edge, the FSM SHALL return to IDLE, pulse error and clear the pending flags.
REQ-026 The timeout counter SHALL restart on every falling edge, saturate rather than wrap, and be sized to hold clk_mhz*timeout_us.
REQ-027 valid and error SHALL never be high in the same cycle.
REQ-028 Back-to-back frames SHALL be accepted with no dead time beyond the stop edge.

Reset
REQ-029 Asserting reset SHALL immediately, including mid-frame, put the FSM in IDLE and clear:
- scancode = 0x00;
- extended, released, valid and error = 0;
- both pending flags, the bit count, the shift register and the timeout counter.
REQ-030 After reset, the filtered clock level SHALL be 1 (bus idle) and the synchronisers SHALL be 1.

Structure
REQ-031 A shared package SHALL hold the constants PS2_PREFIX_EXT=0xE0, PS2_PREFIX_BREAK=0xF0 and PS2_FRAME_BITS=11, plus the FSM state encoding.
REQ-032 Synchronisation and glitch filtering SHALL be one sub-module, uk101_ps2_filter, instantiated once per input line; the filter is used on ps2clk and the data line is only synchronised.

Verification
REQ-033 A clean frame with byte 0x1C at a 12.5 kHz PS/2 clock SHALL give one valid pulse with scancode=0x1C, extended=0, released=0.
REQ-034 The sequence F0,1C SHALL give exactly one valid pulse with scancode=0x1C, released=1, extended=0; the sequence E0,F0,75 SHALL give one valid pulse with scancode=0x75, extended=1, released=1.
REQ-035 Byte 0x1C sent with a flipped parity bit SHALL give one error pulse and no valid pulse; a following 0x32 frame SHALL give valid with scancode=0x32.
REQ-036 A frame stopped after 5 data bits SHALL give one error pulse after 5000 cycles (default parameters); the next good 0x1C frame SHALL be received correctly.
REQ-037 A 3-cycle low glitch on ps2clk in IDLE SHALL produce no state change; reset asserted mid-frame SHALL set all outputs to 0 at once, and a subsequent frame SHALL decode correctly.
